branch_resolve_ctrl: RTL and testbench

- Sequences the 2-bit branch predictor and the front-end redirect path.
- Records each predicted branch in ID in an in-order in-flight queue, then compares it with the actual outcome when the branch resolves in EX/MEM.
- Produces the predictor update strobe, the PC redirect and a multi-cycle pipeline flush.
- Sits between the decode stage, the EX/MEM branch comparator and the predictor.

---
 rtl/branch_resolve_ctrl.sv | 143 ++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: in-order queue of predicted branches, compared
// against EX/MEM outcomes to drive predictor updates, PC redirects and flushes.
module branch_resolve_ctrl #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_push,
  input  logic             id_pred_taken,
  input  logic [XLEN-1:0]  id_target,
  input  logic [XLEN-1:0]  id_pc_plus4,
  input  logic             ex_resolve,
  input  logic             ex_taken,
  output logic             q_full,
  output logic             bp_update,
  output logic             bp_prev_taken,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] mispredict_count,
  output logic             proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  state_e           state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             bp_update_q, bp_update_d;
  logic             bp_prev_taken_q, bp_prev_taken_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
  logic             proto_err_q, proto_err_d;

  logic             ent_pred_q [DEPTH];
  logic [XLEN-1:0]  ent_tgt_q  [DEPTH];
  logic [XLEN-1:0]  ent_pc4_q  [DEPTH];

  logic idle, q_empty, resolve_ok, mispredict, push_ok;

  assign idle       = (state_q == S_IDLE);
  assign q_full     = (count_q == DEPTH_C);
  assign q_empty    = (count_q == '0);
  assign resolve_ok = idle && ex_resolve && !q_empty;
  assign mispredict = resolve_ok && (ent_pred_q[rd_ptr_q] ^ ex_taken);
  // A push in the mispredict cycle is younger than the branch, so it is squashed.
  assign push_ok    = idle && id_push && (!q_full || resolve_ok) && !mispredict;

  always_comb begin
    state_d          = state_q;
    fcnt_d           = fcnt_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    bp_update_d      = resolve_ok;
    bp_prev_taken_d  = resolve_ok && ex_taken;
    redirect_valid_d = mispredict;
    redirect_pc_d    = redirect_pc_q;
    mis_cnt_d        = mis_cnt_q;
    proto_err_d      = proto_err_q;

    if (idle && id_push && q_full && !resolve_ok) proto_err_d = 1'b1;
    if (idle && ex_resolve && q_empty)            proto_err_d = 1'b1;

    if (push_ok)    wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (resolve_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, resolve_ok})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    if (mispredict) begin
      rd_ptr_d      = wr_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = '0;
      redirect_pc_d = ex_taken ? ent_tgt_q[rd_ptr_q] : ent_pc4_q[rd_ptr_q];
      if (mis_cnt_q != {CNT_W{1'b1}}) mis_cnt_d = mis_cnt_q + CNT_W'(1);
      state_d       = S_FLUSH;
      fcnt_d        = FC_W'(FLUSH_CYCLES);
    end

    if (state_q == S_FLUSH) begin
      fcnt_d = fcnt_q - FC_W'(1);
      if (fcnt_q == FC_W'(1)) state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= S_IDLE;
      fcnt_q           <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      bp_update_q      <= 1'b0;
      bp_prev_taken_q  <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mis_cnt_q        <= '0;
      proto_err_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      fcnt_q           <= fcnt_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      bp_update_q      <= bp_update_d;
      bp_prev_taken_q  <= bp_prev_taken_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      mis_cnt_q        <= mis_cnt_d;
      proto_err_q      <= proto_err_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      ent_pred_q[wr_ptr_q] <= id_pred_taken;
      ent_tgt_q[wr_ptr_q]  <= id_target;
      ent_pc4_q[wr_ptr_q]  <= id_pc_plus4;
    end
  end

  assign bp_update        = bp_update_q;
  assign bp_prev_taken    = bp_prev_taken_q;
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign flush            = (state_q == S_FLUSH);
  assign mispredict_count = mis_cnt_q;
  assign proto_err        = proto_err_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Bench for branch_resolve_ctrl: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_branch_resolve_ctrl;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 4;
  localparam int FC      = 2;
  localparam int CNT_W   = 2;
  localparam int MIS_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             id_push = 1'b0;
  logic             id_pred_taken = 1'b0;
  logic [XLEN-1:0]  id_target = '0;
  logic [XLEN-1:0]  id_pc_plus4 = '0;
  logic             ex_resolve = 1'b0;
  logic             ex_taken = 1'b0;
  logic             q_full, bp_update, bp_prev_taken, redirect_valid, flush, proto_err;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] mispredict_count;

  branch_resolve_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .id_push(id_push), .id_pred_taken(id_pred_taken), .id_target(id_target),
    .id_pc_plus4(id_pc_plus4), .ex_resolve(ex_resolve), .ex_taken(ex_taken),
    .q_full(q_full), .bp_update(bp_update), .bp_prev_taken(bp_prev_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .mispredict_count(mispredict_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pred;
    logic [31:0] tgt;
    logic [31:0] pc4;
  } br_t;

  br_t         mq[$];
  int          flush_rem;
  bit          exp_bp, exp_prev, exp_rv, exp_proto;
  logic [31:0] exp_rpc;
  int          exp_mis;
  int          n_total = 0;
  int          n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("bp_update", bp_update, exp_bp);
    if (exp_bp) check_val("bp_prev_taken", bp_prev_taken, exp_prev);
    check_val("redirect_valid", redirect_valid, exp_rv);
    check_val("redirect_pc", redirect_pc, exp_rpc);
    check_val("flush", flush, (flush_rem > 0));
    check_val("q_full", q_full, (mq.size() == DEPTH));
    check_val("mispredict_count", mispredict_count, exp_mis);
    check_val("proto_err", proto_err, exp_proto);
  endtask

  task automatic model_reset();
    mq.delete();
    flush_rem = 0;
    exp_bp = 0; exp_prev = 0; exp_rv = 0; exp_proto = 0;
    exp_rpc = '0;
    exp_mis = 0;
  endtask

  task automatic model_step(input bit p, input bit pr, input logic [31:0] t, input logic [31:0] pc4,
                            input bit r, input bit tk);
    br_t e;
    bit  mis;
    mis = 0;
    exp_bp = 0;
    exp_rv = 0;
    if (flush_rem > 0) begin
      flush_rem--;
    end else begin
      if (r) begin
        if (mq.size() == 0) begin
          exp_proto = 1;
        end else begin
          e = mq.pop_front();
          exp_bp = 1;
          exp_prev = tk;
          if (e.pred != tk) begin
            mis = 1;
            exp_rv = 1;
            exp_rpc = tk ? e.tgt : e.pc4;
            if (exp_mis < MIS_MAX) exp_mis++;
            mq.delete();
            flush_rem = FC;
          end
        end
      end
      if (p && !mis) begin
        if (mq.size() < DEPTH) begin
          e.pred = pr; e.tgt = t; e.pc4 = pc4;
          mq.push_back(e);
        end else begin
          exp_proto = 1;
        end
      end
    end
  endtask

  task automatic cyc(input bit p, input bit pr, input logic [31:0] t, input logic [31:0] pc4,
                     input bit r, input bit tk);
    id_push = p; id_pred_taken = pr; id_target = t; id_pc_plus4 = pc4;
    ex_resolve = r; ex_taken = tk;
    model_step(p, pr, t, pc4, r, tk);
    @(posedge clk);
    #1;
    check_outputs();
    id_push = 0; ex_resolve = 0;
  endtask

  task automatic do_reset();
    id_push = 0; ex_resolve = 0;
    rstn = 0;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Correct taken prediction
    cyc(1, 1, 32'h100, 32'h44, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);

    // Mispredict: predicted not-taken, actually taken
    cyc(1, 0, 32'h200, 32'h80, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);

    // Fill, overflow push, drain in order
    for (int i = 0; i < 4; i++) cyc(1, i[0], 32'h1000 + i, 32'h2000 + i, 0, 0);
    cyc(1, 1, 32'hdead, 32'hbeef, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, i[0]);
    cyc(0, 0, 0, 0, 0, 0);

    // Squash on mispredict with a same-cycle push, then ignored traffic during flush
    do_reset();
    cyc(1, 1, 32'h300, 32'h10, 0, 0);
    cyc(1, 1, 32'h304, 32'h14, 0, 0);
    cyc(1, 0, 32'h308, 32'h18, 0, 0);
    cyc(1, 1, 32'h30c, 32'h1c, 1, 0);
    cyc(1, 1, 32'h310, 32'h20, 1, 1);
    cyc(1, 0, 32'h314, 32'h24, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Empty resolve, then counter saturation
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 32'h400 + i, 32'h500 + i, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
    end

    // Asynchronous reset in the middle of a flush
    cyc(1, 0, 32'h600, 32'h604, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    #3;
    rstn = 0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #1;
    check_outputs();
    cyc(1, 0, 32'h700, 32'h704, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Random traffic, biased toward correct predictions so the queue fills
    for (int n = 0; n < 3000; n++) begin
      bit p, pr, r, tk;
      if (n % 400 == 399) do_reset();
      p  = ($urandom % 2) == 0;
      pr = $urandom % 2;
      r  = ($urandom % 5) < 2;
      if (mq.size() > 0 && ($urandom % 6) != 0) tk = mq[0].pred;
      else tk = $urandom % 2;
      cyc(p, pr, $urandom, $urandom, r, tk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
